// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing the dual-read-port sprite ROM among NUM_REQ requesters.
// Grants up to two requests per cycle (ports A/B); colours return two cycles after grant.
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 17
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [ADDR_W-1:0]             rom_addr_a,
  output logic [ADDR_W-1:0]             rom_addr_b,
  input  logic [23:0]                   rom_data_a,
  input  logic [23:0]                   rom_data_b,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [NUM_REQ*24-1:0]         rdata,
  output logic [$clog2(NUM_REQ)-1:0]    dbg_ptr
);

  localparam int PTR_W = $clog2(NUM_REQ);

  // Handshake: a requester holds req high with a stable req_addr until it sees
  // gnt in the same cycle; it may drop req or change req_addr the cycle after.
  // rvalid is a one-cycle strobe two cycles after gnt; rdata holds until the
  // same requester's next response.

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic                  tag_a_vld_q, tag_a_vld_d;
  logic                  tag_b_vld_q, tag_b_vld_d;
  logic [PTR_W-1:0]      tag_a_idx_q, tag_a_idx_d;
  logic [PTR_W-1:0]      tag_b_idx_q, tag_b_idx_d;
  logic [NUM_REQ-1:0]    rvalid_q, rvalid_d;
  logic [NUM_REQ*24-1:0] rdata_q, rdata_d;

  logic found_a, found_b;
  int   a_i, b_i, scan_idx;

  // Arbitration: A is the first requester in circular order from ptr, B the next one.
  always_comb begin
    found_a  = 1'b0;
    found_b  = 1'b0;
    a_i      = 0;
    b_i      = 0;
    scan_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = (int'(ptr_q) + k) % NUM_REQ;
      if (req[scan_idx]) begin
        if (!found_a) begin
          found_a = 1'b1;
          a_i     = scan_idx;
        end else if (!found_b) begin
          found_b = 1'b1;
          b_i     = scan_idx;
        end
      end
    end
    if (!Reset_n) begin
      found_a = 1'b0;
      found_b = 1'b0;
    end

    gnt         = '0;
    rom_addr_a  = '0;
    rom_addr_b  = '0;
    ptr_d       = ptr_q;
    tag_a_vld_d = found_a;
    tag_b_vld_d = found_b;
    tag_a_idx_d = PTR_W'(a_i);
    tag_b_idx_d = PTR_W'(b_i);

    if (found_a) begin
      gnt[a_i]   = 1'b1;
      rom_addr_a = req_addr[a_i*ADDR_W +: ADDR_W];
      ptr_d      = PTR_W'((a_i + 1) % NUM_REQ);
    end
    if (found_b) begin
      gnt[b_i]   = 1'b1;
      rom_addr_b = req_addr[b_i*ADDR_W +: ADDR_W];
      ptr_d      = PTR_W'((b_i + 1) % NUM_REQ);
    end
  end

  // Response stage: A and B tags never share an index, so the two writes cannot collide.
  always_comb begin
    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (tag_a_vld_q) begin
      rvalid_d[tag_a_idx_q]                = 1'b1;
      rdata_d[int'(tag_a_idx_q)*24 +: 24]  = rom_data_a;
    end
    if (tag_b_vld_q) begin
      rvalid_d[tag_b_idx_q]                = 1'b1;
      rdata_d[int'(tag_b_idx_q)*24 +: 24]  = rom_data_b;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      ptr_q       <= '0;
      tag_a_vld_q <= 1'b0;
      tag_b_vld_q <= 1'b0;
      tag_a_idx_q <= '0;
      tag_b_idx_q <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
    end else begin
      ptr_q       <= ptr_d;
      tag_a_vld_q <= tag_a_vld_d;
      tag_b_vld_q <= tag_b_vld_d;
      tag_a_idx_q <= tag_a_idx_d;
      tag_b_idx_q <= tag_b_idx_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign dbg_ptr = ptr_q;

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares the dual-read-port sprite ROM (17-bit address, registered palette-index read, combinational 24-bit colour decode) among NUM_REQ sprite/background requesters.
- Each cycle it grants up to two requests round-robin, one on ROM port A and one on port B.
- It drives both ROM read addresses and routes the returned 24-bit colours back to the granted requesters with a fixed latency.
- Sits between the sprite/maze drawing engines and the sprite ROM, ahead of the VGA colour mapper.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- ADDR_W, 17: ROM address width.

Ports:
- Clk  in  1  system clock; all state updates on its rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- req  in  NUM_REQ  per-requester read request; held high with a stable address until granted.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- gnt  out  NUM_REQ  combinational one-cycle grant per requester.
- rom_addr_a  out  ADDR_W  to ROM read_address.
- rom_addr_b  out  ADDR_W  to ROM read_address2.
- rom_data_a  in  24  ROM data_Out (valid one cycle after the address is presented).
- rom_data_b  in  24  ROM data_Out2.
- rvalid  out  NUM_REQ  registered one-cycle response strobe.
- rdata  out  NUM_REQ*24  registered per-requester colour, held until that requester's next response.

Behaviour:

Reset (Reset_n low at a rising edge):
- ptr <= 0; in-flight tags cleared; rvalid <= 0; all rdata <= 24'h000000.
- gnt is 0 while Reset_n is low.
- A reset mid-operation drops in-flight reads: no rvalid is issued for them.

Arbitration (combinational, cycle t):
- Winner A = first i with req[i]=1, scanning ptr, ptr+1, … mod NUM_REQ.
- Winner B = first requesting index after A in the same circular scan, excluding A.
- gnt[A] and gnt[B] are asserted in cycle t. At most two gnt bits are high; never the same index twice.
- rom_addr_a = req_addr[A], rom_addr_b = req_addr[B].
- An unused port drives address 0, and its tag is marked invalid.
- Pointer update: if any grant, ptr <= (last granted index + 1) mod NUM_REQ. B counts as last if granted, else A. With no grant, ptr holds.

Pipeline:
- Stage 1 (edge ending t): tag_a/tag_b <= {valid, index}. The ROM registers its indices at the same edge.
- Cycle t+1: rom_data_a/b are valid.
- Stage 2 (edge ending t+1): for each valid tag, rdata[tag] <= rom_data_x and rvalid[tag] <= 1. All other rvalid bits are 0.
- Latency: grant in cycle t gives rvalid/rdata visible in cycle t+2.
- Throughput: 2 reads per cycle, fully pipelined, no stalls.

Handshake:
- The requester may drop req or change its address in the cycle after gnt.
- A requester granted on consecutive cycles gets in-order rvalid pulses on consecutive cycles.
- Simultaneous A/B responses target different indices, so there is no write conflict on rdata.

Boundaries:
- Single requester: only port A is used.
- Wrap-around: ptr = NUM_REQ-1 scanning to index 0 is legal.
- Addresses are passed through unmodified (0 .. 2^ADDR_W-1); no range check is performed.

Test Plan:
- Reset: hold Reset_n=0 for 3 cycles with req=4'b1111 -> gnt=0 and rvalid=0 throughout, rdata all 0; after release, first grants are indices 0 and 1.
- Round-robin: req=4'b1111 held for 4 cycles, ROM model returning colour = {7'b0, addr} -> gnt sequence 0011, 1100, 0011, 1100. Each rvalid arrives 2 cycles after its grant, with rdata equal to the model colour for that requester's address.
- Single requester with wrap: ptr=3 (after granting 1,2), req=4'b0001, addr=17'h1F000 -> gnt=0001 on port A, rom_addr_b=0; at t+2, rvalid=0001 and rdata[0] equals model(17'h1F000); ptr becomes 1.
- Back-to-back pipelining: requester 2 granted on 3 consecutive cycles with addresses 5, 6, 7 -> three consecutive rvalid[2] pulses carrying model(5), model(6), model(7) in order.
- Reset mid-flight: grant at t, Reset_n=0 at the edge ending t+1 -> no rvalid in t+2, rdata reads 0, ptr reads 0.
- Idle: req=0 for 5 cycles -> gnt=0, rom_addr_a=rom_addr_b=0, ptr unchanged, rdata holds its last values.
